nibble_add_sequencer: RTL and testbench
=======================================

# nibble_add_sequencer

Shares one instance of the team's 4-bit ripple-carry adder (`ra`) between two requesters and sequences it over multi-nibble operands. Each accepted request is added one nibble per cycle, least-significant nibble first, with the carry held in a register between nibbles. The result is presented on a single valid/ready output port tagged with the requester ID. Arbitration between the two requesters is round-robin.

## Interface
Parameters:
- `NIBBLES`, default 4: operand width W = 4*NIBBLES bits; must be ≥ 1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_a`, `req0_b` in W: requester 0 operands.
- `req0_cin` in 1: requester 0 carry-in.
- `req0_ready` out 1: requester 0 is accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_cin`, `req1_ready`: same as requester 0, for requester 1.
- `res_valid` out 1: a result is held on the output.
- `res_id` out 1: which requester the result belongs to.
- `res_sum` out W: the sum.
- `res_cout` out 1: carry out of the top nibble.
- `res_ready` in 1: the consumer takes the result.
- `busy` out 1: high in RUN or DONE.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: adding one nibble per cycle.
  - DONE: holding the result.
- Reset (`rst_n` low, at any time, including mid-operation):
  - State goes to IDLE; the nibble index, carry register, round-robin pointer `rr`, `res_sum`, `res_cout` and `res_id` all go to 0.
  - `res_valid` = 0, `busy` = 0, and both readies are forced to 0 while reset is held.
  - An operation in flight is discarded; it produces no result.
- Arbitration (IDLE only):
  - Only one valid: that requester is selected.
  - Both valid: requester `rr` is selected.
  - `reqN_ready` is combinational: it is 1 when the state is IDLE, `reqN_valid` = 1 and N is selected. At most one ready is high at a time.
  - Transfer happens when valid and ready are both high. On that edge the block captures A, B, cin and the ID, sets `rr` to the other requester (1 − ID), clears the nibble index and enters RUN.
  - Requesters must hold valid and their operands stable until ready is seen.
  - A requester that is not selected waits. Its ready stays 0; nothing is dropped.
- RUN, nibble index k = 0 … NIBBLES−1:
  - The adder inputs are A[4k+3:4k], B[4k+3:4k], and a carry-in equal to the captured cin when k = 0, otherwise the carry register.
  - On each edge: the adder sum is written to `res_sum[4k+3:4k]`, its carry-out is written to the carry register, and k increments.
  - On the edge where k = NIBBLES−1: the carry-out is written to `res_cout`, `res_id` is set to the captured ID, `res_valid` goes to 1 and the state moves to DONE.
- DONE:
  - `res_valid`, `res_sum`, `res_cout` and `res_id` are held stable while `res_ready` = 0.
  - When `res_ready` = 1: on that edge `res_valid` goes to 0 and the state returns to IDLE.
  - No request is accepted in RUN or DONE.
- Arithmetic: modulo 2^W, with the carry out reported separately in `res_cout`. `res_sum` bits above the current k are don't-care until `res_valid` goes high.

## Timing
- Accept edge E0 → `res_valid` rises at edge E0+NIBBLES (4 cycles for the default).
- `res_ready` may already be high when `res_valid` rises; the result is then consumed on the next edge (E0+NIBBLES+1).
- Back-to-back accepts are at least NIBBLES+2 edges apart: NIBBLES RUN cycles, at least one DONE cycle, then one IDLE cycle in which the next accept happens.
- `busy` is registered: it is high from E0 until the edge that leaves DONE.
- Reset is asynchronous: outputs reach their reset values without a clock edge. Deassertion of `rst_n` is synchronised outside this block.

## Test plan
All scenarios use NIBBLES = 4.
- **Basic add, full carry ripple:** req0 A=0xFFFF, B=0x0001, cin=0 → 4 cycles after accept, `res_sum`=0x0000, `res_cout`=1, `res_id`=0.
- **Carry-in:** req1 A=0x1234, B=0x4321, cin=1 → `res_sum`=0x5556, `res_cout`=0, `res_id`=1.
- **Carry across nibble boundaries:** A=0x0F0F, B=0x00F1, cin=0 → `res_sum`=0x1000, `res_cout`=0.
- **Simultaneous requests after reset:** both valid → req0 served first (`res_id`=0). Then, with `res_ready` held at 1, req1 is accepted at the next IDLE cycle and served (`res_id`=1). Next, with both valid again, req0 is served first.
- **Back-pressure:** hold `res_ready`=0 for 10 cycles in DONE → result fields stay stable, `res_valid` stays 1, both readies stay 0 even while req1_valid=1. Release `res_ready` → DONE→IDLE on that edge, and req1 is accepted one edge later.
- **Reset mid-operation:** pull `rst_n` low at nibble index 2 of RUN → immediately all outputs are 0 and `busy`=0. Release reset with req0 valid → req0 is accepted in IDLE and its full result is produced correctly. The aborted operation never produces a result.

Source files
------------

// File: rtl/nibble_add_sequencer.sv
// Shares one 4-bit ripple adder between two requesters, one nibble per cycle.
// Ports: req0/req1 valid-ready operand inputs, res valid-ready result output, busy.
module nibble_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  input  logic [4*NIBBLES-1:0]   req0_a,
  input  logic [4*NIBBLES-1:0]   req0_b,
  input  logic                   req0_cin,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [4*NIBBLES-1:0]   req1_a,
  input  logic [4*NIBBLES-1:0]   req1_b,
  input  logic                   req1_cin,
  output logic                   req1_ready,
  output logic                   res_valid,
  output logic                   res_id,
  output logic [4*NIBBLES-1:0]   res_sum,
  output logic                   res_cout,
  input  logic                   res_ready,
  output logic                   busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          rr_q, rr_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          cin_q, cin_d;
  logic          id_q, id_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          rid_q, rid_d;
  logic          vld_q, vld_d;
  logic          busy_q, busy_d;

  // Arbitration; readies stay low while reset is asserted.
  logic idle;
  logic sel1;

  assign idle = rst_n && (state_q == S_IDLE);
  assign sel1 = req1_valid && (!req0_valid || rr_q);

  assign req0_ready = idle && req0_valid && !sel1;
  assign req1_ready = idle && sel1;

  // Shared 4-bit ripple-carry adder on the current nibble.
  logic [IW+1:0] sh;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [3:0]    ra_a;
  logic [3:0]    ra_b;
  logic [3:0]    ra_s;
  logic [4:0]    ra_c;
  logic [W-1:0]  nib_mask;
  logic [W-1:0]  nib_val;

  assign sh   = {idx_q, 2'b00};
  assign a_sh = a_q >> sh;
  assign b_sh = b_q >> sh;
  assign ra_a = a_sh[3:0];
  assign ra_b = b_sh[3:0];

  assign ra_c[0] = (idx_q == '0) ? cin_q : carry_q;

  for (genvar i = 0; i < 4; i++) begin : g_ra
    assign ra_s[i]   = ra_a[i] ^ ra_b[i] ^ ra_c[i];
    assign ra_c[i+1] = (ra_a[i] & ra_b[i]) |
                       (ra_c[i] & (ra_a[i] ^ ra_b[i]));
  end

  assign nib_mask = W'(4'hF) << sh;
  assign nib_val  = W'(ra_s) << sh;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    rr_d    = rr_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    id_d    = id_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    rid_d   = rid_q;
    vld_d   = vld_q;
    busy_d  = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          a_d     = req1_ready ? req1_a : req0_a;
          b_d     = req1_ready ? req1_b : req0_b;
          cin_d   = req1_ready ? req1_cin : req0_cin;
          id_d    = req1_ready;
          rr_d    = !req1_ready;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d   = (sum_q & ~nib_mask) | nib_val;
        carry_d = ra_c[4];
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST) begin
          idx_d   = '0;
          cout_d  = ra_c[4];
          rid_d   = id_q;
          vld_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          vld_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      rr_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      id_q    <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      rid_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      rr_q    <= rr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      rid_q   <= rid_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  assign res_valid = vld_q;
  assign res_id    = rid_q;
  assign res_sum   = sum_q;
  assign res_cout  = cout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Bench for nibble_add_sequencer: table vectors, directed corners, random traffic.
// Reference: whole-word arithmetic plus a pending-request / round-robin model.
module tb_nibble_add_sequencer;

  localparam int NIB = 4;
  localparam int W   = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_cin, req0_ready;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_cin, req1_ready;
  logic [W-1:0] req1_a, req1_b;
  logic         res_valid, res_id, res_cout, res_ready, busy;
  logic [W-1:0] res_sum;

  always #5 clk = ~clk;

  nibble_add_sequencer #(.NIBBLES(NIB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t tbl[8];

  int vec_cnt = 0;
  int err_cnt = 0;

  logic         p_v[2];
  logic [W-1:0] p_a[2];
  logic [W-1:0] p_b[2];
  logic         p_c[2];
  logic         rr_m;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void apply();
    req0_valid = p_v[0];
    req0_a     = p_a[0];
    req0_b     = p_b[0];
    req0_cin   = p_c[0];
    req1_valid = p_v[1];
    req1_a     = p_a[1];
    req1_b     = p_b[1];
    req1_cin   = p_c[1];
  endfunction

  function automatic logic winner();
    return (p_v[0] && p_v[1]) ? rr_m : p_v[1];
  endfunction

  function automatic logic [W:0] model(input logic w);
    return {1'b0, p_a[w]} + {1'b0, p_b[w]} + (W+1)'(p_c[w]);
  endfunction

  task automatic post(input logic id, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic cin);
    p_v[id] = 1'b1;
    p_a[id] = a;
    p_b[id] = b;
    p_c[id] = cin;
    apply();
  endtask

  // One full transaction, starting in IDLE with requests already applied.
  task automatic serve(input logic [W-1:0] es, input logic ec,
                       input int hold, input bit early,
                       input string tag);
    logic w;
    int   lat;
    w = winner();
    #1;
    chk({tag, " ready"}, {30'd0, req1_ready, req0_ready},
        w ? 32'd2 : 32'd1);
    step();
    p_v[w] = 1'b0;
    apply();
    rr_m = ~w;
    if (early) res_ready = 1'b1;
    chk({tag, " busy"}, busy, 1);
    lat = 0;
    while (!res_valid && lat < 12) begin
      step();
      lat++;
    end
    chk({tag, " latency"}, lat, NIB);
    chk({tag, " sum"}, res_sum, es);
    chk({tag, " cout"}, res_cout, ec);
    chk({tag, " id"}, res_id, w);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, " hold valid"}, res_valid, 1);
      chk({tag, " hold sum"}, {res_id, res_cout, res_sum},
          {w, ec, es});
      chk({tag, " hold ready"}, {req1_ready, req0_ready}, 0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({tag, " drain valid"}, res_valid, 0);
    chk({tag, " drain busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W:0] e;
    logic       w;

    tbl[0] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tbl[1] = '{1'b1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    tbl[2] = '{1'b0, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    tbl[3] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[4] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tbl[5] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[6] = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1};
    tbl[7] = '{1'b1, 16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0};

    rst_n     = 1'b0;
    res_ready = 1'b0;
    rr_m      = 1'b0;
    for (int k = 0; k < 2; k++) begin
      p_v[k] = 1'b1;
      p_a[k] = '0;
      p_b[k] = '0;
      p_c[k] = 1'b0;
    end
    apply();

    #2;
    chk("reset valid", res_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset readies", {req1_ready, req0_ready}, 0);
    chk("reset result", {res_id, res_cout, res_sum}, 0);
    p_v[0] = 1'b0;
    p_v[1] = 1'b0;
    apply();
    step();
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      post(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].cin);
      serve(tbl[i].sum, tbl[i].cout, i % 3, 1'b0, "tbl");
    end

    // Simultaneous requests straight after reset.
    rst_n = 1'b0;
    rr_m  = 1'b0;
    step();
    rst_n = 1'b1;
    post(1'b0, 16'h1111, 16'h2222, 1'b0);
    post(1'b1, 16'h0F00, 16'h0100, 1'b1);
    serve(16'h3333, 1'b0, 0, 1'b0, "sim0");
    serve(16'h1001, 1'b0, 0, 1'b0, "sim1");
    post(1'b0, 16'hFFF0, 16'h0010, 1'b0);
    post(1'b1, 16'h7000, 16'h9000, 1'b0);
    // req0 wins; req1 stays valid through 10 back-pressured cycles.
    serve(16'h0000, 1'b1, 10, 1'b0, "bp");
    serve(16'h0000, 1'b1, 0, 1'b0, "bp next");

    // Reset in the middle of RUN.
    post(1'b0, 16'hDEAD, 16'h1111, 1'b1);
    #1;
    chk("mid ready", req0_ready, 1);
    step();
    p_v[0] = 1'b0;
    apply();
    step();
    step();
    rst_n = 1'b0;
    rr_m  = 1'b0;
    post(1'b0, 16'h0123, 16'h0FFF, 1'b0);
    #1;
    chk("mid rst valid", res_valid, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst result", {res_id, res_cout, res_sum}, 0);
    chk("mid rst readies", {req1_ready, req0_ready}, 0);
    step();
    chk("mid rst hold", {res_valid, busy, req0_ready}, 0);
    rst_n = 1'b1;
    serve(16'h1122, 1'b0, 1, 1'b0, "post rst");

    // Random traffic against the pending/round-robin model.
    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!p_v[k] && $urandom_range(0, 1) == 1) begin
          post(k[0], W'($urandom), W'($urandom),
               1'($urandom_range(0, 1)));
        end
      end
      if (!p_v[0] && !p_v[1]) begin
        #1;
        chk("rand idle ready", {req1_ready, req0_ready}, 0);
        step();
        continue;
      end
      w = winner();
      e = model(w);
      if ($urandom_range(0, 1) == 1)
        serve(e[W-1:0], e[W], 0, 1'b1, "rand");
      else
        serve(e[W-1:0], e[W], $urandom_range(0, 3), 1'b0, "rand");
    end
    while (p_v[0] || p_v[1]) begin
      w = winner();
      e = model(w);
      serve(e[W-1:0], e[W], 0, 1'b0, "drain");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
